// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap sequencer owning the CSR file write port.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   inst_ecall/ebreak/mret, inst_pc trap-causing instruction in execute and its PC
//   next_pc                         PC of next sequential instruction (interrupt epc)
//   irq_req, glb_int_en, csr_mie    external interrupt request and enables
//   csr_mstatus/mtvec/mepc          current CSR values, snapshotted at trap entry
//   ex_csr_wren/wraddr/wrdata       execute-stage CSR write, passed through in IDLE
//   csr_wren/wraddr/wrdata          CSR file write port
//   hold                            pipeline stall request
//   jump_en, jump_addr              PC redirect
// Optional: define TRAP_MTVAL_EN to add a W_MTVAL write after W_MCAUSE.
module trap_ctrl #(
    parameter logic [31:0] IRQ_CAUSE   = 32'h8000000B,
    parameter bit          VECTORED_EN = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inst_ecall,
    input  logic        inst_ebreak,
    input  logic        inst_mret,
    input  logic [31:0] inst_pc,
    input  logic [31:0] next_pc,
    input  logic        irq_req,
    input  logic        glb_int_en,
    input  logic [31:0] csr_mie,
    input  logic [31:0] csr_mstatus,
    input  logic [31:0] csr_mtvec,
    input  logic [31:0] csr_mepc,
    input  logic        ex_csr_wren,
    input  logic [11:0] ex_csr_wraddr,
    input  logic [31:0] ex_csr_wrdata,
    output logic        csr_wren,
    output logic [11:0] csr_wraddr,
    output logic [31:0] csr_wrdata,
    output logic        hold,
    output logic        jump_en,
    output logic [31:0] jump_addr
);
    localparam logic [11:0] MSTATUS = 12'h300;
    localparam logic [11:0] MEPC    = 12'h341;
    localparam logic [11:0] MCAUSE  = 12'h342;

`ifdef TRAP_MTVAL_EN
    localparam logic [11:0] MTVAL   = 12'h343;
    typedef enum logic [2:0] {IDLE, W_MEPC, W_MCAUSE, W_MTVAL, W_MSTATUS, M_MSTATUS, JUMP} state_t;
    logic [31:0] mtval_q, mtval_d;
`else
    typedef enum logic [2:0] {IDLE, W_MEPC, W_MCAUSE, W_MSTATUS, M_MSTATUS, JUMP} state_t;
`endif

    state_t      state_q, state_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] mstatus_q, mstatus_d;
    logic [31:0] tgt_q, tgt_d;
    logic        irq, req, exc, is_mret;
    logic [31:0] base;
    logic        unused;

    assign unused = ^{csr_mie[31:12], csr_mie[10:0], csr_mepc[1:0]};

    assign irq     = irq_req & glb_int_en & csr_mie[11];
    assign exc     = inst_ecall | inst_ebreak;
    assign is_mret = inst_mret & ~exc;
    assign req     = exc | inst_mret | irq;
    assign base    = {csr_mtvec[31:2], 2'b00};

    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        epc_d     = epc_q;
        mstatus_d = mstatus_q;
        tgt_d     = tgt_q;
`ifdef TRAP_MTVAL_EN
        mtval_d   = mtval_q;
`endif
        case (state_q)
            IDLE: if (req) begin
                state_d   = is_mret ? M_MSTATUS : W_MEPC;
                cause_d   = inst_ecall ? 32'd11 : inst_ebreak ? 32'd3 : IRQ_CAUSE;
                epc_d     = exc ? inst_pc : next_pc;
                mstatus_d = csr_mstatus;
                // Only a taken interrupt may use the vectored target; exceptions use the base.
                tgt_d     = is_mret ? {csr_mepc[31:2], 2'b00}
                          : (!exc && VECTORED_EN && csr_mtvec[1:0] == 2'b01) ? base + {IRQ_CAUSE[29:0], 2'b00}
                          : base;
`ifdef TRAP_MTVAL_EN
                mtval_d   = (inst_ebreak && !inst_ecall) ? inst_pc : 32'd0;
`endif
            end
            W_MEPC:    state_d = W_MCAUSE;
`ifdef TRAP_MTVAL_EN
            W_MCAUSE:  state_d = W_MTVAL;
            W_MTVAL:   state_d = W_MSTATUS;
`else
            W_MCAUSE:  state_d = W_MSTATUS;
`endif
            W_MSTATUS: state_d = JUMP;
            M_MSTATUS: state_d = JUMP;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cause_q   <= '0;
            epc_q     <= '0;
            mstatus_q <= '0;
            tgt_q     <= '0;
`ifdef TRAP_MTVAL_EN
            mtval_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            epc_q     <= epc_d;
            mstatus_q <= mstatus_d;
            tgt_q     <= tgt_d;
`ifdef TRAP_MTVAL_EN
            mtval_q   <= mtval_d;
`endif
        end
    end

    // Outputs are gated by rst_n so they read zero for the whole reset, not just after an edge.
    always_comb begin
        csr_wren   = 1'b0;
        csr_wraddr = '0;
        csr_wrdata = '0;
        hold       = 1'b0;
        jump_en    = 1'b0;
        jump_addr  = '0;
        if (rst_n) begin
            case (state_q)
                IDLE: begin
                    csr_wren   = ex_csr_wren;
                    csr_wraddr = ex_csr_wraddr;
                    csr_wrdata = ex_csr_wrdata;
                    hold       = req;
                end
                W_MEPC: begin
                    csr_wren   = 1'b1;
                    csr_wraddr = MEPC;
                    csr_wrdata = epc_q;
                    hold       = 1'b1;
                end
                W_MCAUSE: begin
                    csr_wren   = 1'b1;
                    csr_wraddr = MCAUSE;
                    csr_wrdata = cause_q;
                    hold       = 1'b1;
                end
`ifdef TRAP_MTVAL_EN
                W_MTVAL: begin
                    csr_wren   = 1'b1;
                    csr_wraddr = MTVAL;
                    csr_wrdata = mtval_q;
                    hold       = 1'b1;
                end
`endif
                W_MSTATUS: begin
                    csr_wren   = 1'b1;
                    csr_wraddr = MSTATUS;
                    csr_wrdata = {mstatus_q[31:13], 2'b11, mstatus_q[10:8], mstatus_q[3],
                                  mstatus_q[6:4], 1'b0, mstatus_q[2:0]};
                    hold       = 1'b1;
                end
                M_MSTATUS: begin
                    csr_wren   = 1'b1;
                    csr_wraddr = MSTATUS;
                    csr_wrdata = {mstatus_q[31:8], 1'b1, mstatus_q[6:4], mstatus_q[7], mstatus_q[2:0]};
                    hold       = 1'b1;
                end
                default: begin
                    hold      = 1'b1;
                    jump_en   = 1'b1;
                    jump_addr = tgt_q;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed self-checking bench for trap_ctrl.
module tb_trap_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        inst_ecall = 1'b0, inst_ebreak = 1'b0, inst_mret = 1'b0;
    logic [31:0] inst_pc = '0, next_pc = '0;
    logic        irq_req = 1'b0, glb_int_en = 1'b0;
    logic [31:0] csr_mie = '0, csr_mstatus = '0, csr_mtvec = '0, csr_mepc = '0;
    logic        ex_csr_wren = 1'b1;
    logic [11:0] ex_csr_wraddr = 12'h340;
    logic [31:0] ex_csr_wrdata = 32'hDEAD;
    logic        csr_wren, hold, jump_en;
    logic [11:0] csr_wraddr;
    logic [31:0] csr_wrdata, jump_addr;
    int          total = 0, passed = 0, fails = 0;

    always #5 clk = ~clk;

    trap_ctrl #(.VECTORED_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .inst_ecall(inst_ecall), .inst_ebreak(inst_ebreak), .inst_mret(inst_mret),
        .inst_pc(inst_pc), .next_pc(next_pc),
        .irq_req(irq_req), .glb_int_en(glb_int_en), .csr_mie(csr_mie),
        .csr_mstatus(csr_mstatus), .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc),
        .ex_csr_wren(ex_csr_wren), .ex_csr_wraddr(ex_csr_wraddr), .ex_csr_wrdata(ex_csr_wrdata),
        .csr_wren(csr_wren), .csr_wraddr(csr_wraddr), .csr_wrdata(csr_wrdata),
        .hold(hold), .jump_en(jump_en), .jump_addr(jump_addr)
    );

    function automatic logic [78:0] ov(input logic w, input logic [11:0] a, input logic [31:0] d,
                                       input logic h, input logic j, input logic [31:0] ja);
        return {w, a, d, h, j, ja};
    endfunction

    task automatic chk(input string tag, input logic [78:0] exp);
        logic [78:0] obs;
        obs = {csr_wren, csr_wraddr, csr_wrdata, hold, jump_en, jump_addr};
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    initial begin
        tick;
        chk("reset_zero", ov(0, 0, 0, 0, 0, 0));
        rst_n = 1'b1;
        #1 chk("passthrough", ov(1, 12'h340, 32'hDEAD, 0, 0, 0));

        // ecall, snapshot must ignore later input changes
        inst_ecall = 1; inst_pc = 32'h100; next_pc = 32'h104; csr_mtvec = 32'h200; csr_mstatus = 32'h8;
        ex_csr_wraddr = 12'h340; ex_csr_wrdata = 32'h1;
        #1 chk("ecall_T", ov(1, 12'h340, 32'h1, 1, 0, 0));
        tick;
        inst_ecall = 0; csr_mstatus = 32'hFFFF_FFFF; csr_mtvec = 32'h999;
        #1 chk("ecall_mepc", ov(1, 12'h341, 32'h100, 1, 0, 0));
        tick; chk("ecall_mcause", ov(1, 12'h342, 32'd11, 1, 0, 0));
`ifdef TRAP_MTVAL_EN
        tick; chk("ecall_mtval", ov(1, 12'h343, 32'h0, 1, 0, 0));
`endif
        tick; chk("ecall_mstatus", ov(1, 12'h300, 32'h1880, 1, 0, 0));
        tick; chk("ecall_jump", ov(0, 0, 0, 1, 1, 32'h200));
        tick; chk("ecall_idle", ov(1, 12'h340, 32'h1, 0, 0, 0));

        // vectored interrupt
        ex_csr_wren = 0; ex_csr_wraddr = 0; ex_csr_wrdata = 0;
        irq_req = 1; glb_int_en = 1; csr_mie = 32'h800; next_pc = 32'h44; csr_mtvec = 32'h301; csr_mstatus = 32'h8;
        #1 chk("irq_T", ov(0, 0, 0, 1, 0, 0));
        tick;
        irq_req = 0;
        #1 chk("irq_mepc", ov(1, 12'h341, 32'h44, 1, 0, 0));
        tick; chk("irq_mcause", ov(1, 12'h342, 32'h8000000B, 1, 0, 0));
`ifdef TRAP_MTVAL_EN
        tick; chk("irq_mtval", ov(1, 12'h343, 32'h0, 1, 0, 0));
`endif
        tick; chk("irq_mstatus", ov(1, 12'h300, 32'h1880, 1, 0, 0));
        tick; chk("irq_jump", ov(0, 0, 0, 1, 1, 32'h32C));
        tick; chk("irq_idle", ov(0, 0, 0, 0, 0, 0));

        // masked interrupts
        irq_req = 1; glb_int_en = 0; ex_csr_wren = 1; ex_csr_wraddr = 12'h340; ex_csr_wrdata = 32'hDEAD;
        #1 chk("mask_mie_global", ov(1, 12'h340, 32'hDEAD, 0, 0, 0));
        tick; chk("mask_stays_idle", ov(1, 12'h340, 32'hDEAD, 0, 0, 0));
        glb_int_en = 1; csr_mie = 32'hFFFF_F7FF;
        #1 chk("mask_mie_bit11", ov(1, 12'h340, 32'hDEAD, 0, 0, 0));
        tick;
        irq_req = 0; csr_mie = 32'h800;

        // mret
        inst_mret = 1; csr_mstatus = 32'h1880; csr_mepc = 32'h104;
        #1 chk("mret_T", ov(1, 12'h340, 32'hDEAD, 1, 0, 0));
        tick;
        inst_mret = 0; csr_mepc = 32'h0;
        #1 chk("mret_mstatus", ov(1, 12'h300, 32'h1888, 1, 0, 0));
        tick; chk("mret_jump", ov(0, 0, 0, 1, 1, 32'h104));
        tick; chk("mret_idle", ov(1, 12'h340, 32'hDEAD, 0, 0, 0));

        // ebreak with vectored mtvec: exceptions still go to base
        inst_ebreak = 1; inst_pc = 32'h80; csr_mtvec = 32'h301; csr_mstatus = 32'h0;
        tick;
        inst_ebreak = 0;
        #1 chk("ebreak_mepc", ov(1, 12'h341, 32'h80, 1, 0, 0));
        tick; chk("ebreak_mcause", ov(1, 12'h342, 32'd3, 1, 0, 0));
`ifdef TRAP_MTVAL_EN
        tick; chk("ebreak_mtval", ov(1, 12'h343, 32'h80, 1, 0, 0));
`endif
        tick; chk("ebreak_mstatus", ov(1, 12'h300, 32'h1800, 1, 0, 0));
        tick; chk("ebreak_jump", ov(0, 0, 0, 1, 1, 32'h300));

        // ecall and irq together: ecall wins, irq taken afterwards
        tick;
        inst_ecall = 1; irq_req = 1; glb_int_en = 1; inst_pc = 32'h200; next_pc = 32'h204; csr_mstatus = 32'h8;
        tick;
        inst_ecall = 0;
        #1 chk("both_mepc", ov(1, 12'h341, 32'h200, 1, 0, 0));
        tick; chk("both_mcause", ov(1, 12'h342, 32'd11, 1, 0, 0));
`ifdef TRAP_MTVAL_EN
        tick;
`endif
        tick; tick; chk("both_jump", ov(0, 0, 0, 1, 1, 32'h300));
        tick; chk("both_irq_T", ov(1, 12'h340, 32'hDEAD, 1, 0, 0));
        tick; chk("both_irq_mepc", ov(1, 12'h341, 32'h204, 1, 0, 0));
        irq_req = 0;
        tick; chk("both_irq_mcause", ov(1, 12'h342, 32'h8000000B, 1, 0, 0));

        // reset mid-sequence
        rst_n = 0;
        #1 chk("rst_mid_zero", ov(0, 0, 0, 0, 0, 0));
        tick;
        rst_n = 1;
        #1 chk("rst_mid_idle", ov(1, 12'h340, 32'hDEAD, 0, 0, 0));
        tick; chk("rst_mid_stay", ov(1, 12'h340, 32'hDEAD, 0, 0, 0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
